// File: rtl/ast_packet_arbiter_pkg.sv
// Shared constants and types for the packet arbiter in front of the width converter.
package ast_packet_arbiter_pkg;
  localparam int DATA_IN_W = 64;
  localparam int N_SRC     = 4;
  localparam int DATA_W    = DATA_IN_W;
  localparam int CHANNEL_W = 10;
  localparam int EMPTY_W   = ($clog2(DATA_W/8) < 1) ? 1 : $clog2(DATA_W/8);
  localparam int IDX_W     = ($clog2(N_SRC) < 1) ? 1 : $clog2(N_SRC);

  typedef logic [N_SRC-1:0] src_mask_t;
  typedef logic [IDX_W-1:0] src_idx_t;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
endpackage

// File: rtl/ast_packet_arbiter_if.sv
// Avalon-ST bundle; NUM_LANES sources side by side, or a single lane toward the converter.
interface ast_packet_arbiter_if #(parameter int NUM_LANES = 1);
  import ast_packet_arbiter_pkg::*;
  logic [NUM_LANES-1:0][DATA_W-1:0]    data;
  logic [NUM_LANES-1:0][EMPTY_W-1:0]   empty;
  logic [NUM_LANES-1:0][CHANNEL_W-1:0] channel;
  logic [NUM_LANES-1:0]                startofpacket;
  logic [NUM_LANES-1:0]                endofpacket;
  logic [NUM_LANES-1:0]                valid;
  logic [NUM_LANES-1:0]                ready;

  modport master (output data, empty, channel, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, empty, channel, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/ast_packet_arbiter_rr_pick.sv
// Combinational winner select. ARB_FIXED_PRIO_EN: lowest index wins; otherwise
// round robin starting just after the last granted source.
module ast_rr_pick
  import ast_packet_arbiter_pkg::*;
(
  input  src_mask_t req,
  input  src_idx_t  last,
  output src_idx_t  winner,
  output logic      any_req
);
  assign any_req = |req;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    winner = '0;
    for (int k = N_SRC-1; k >= 0; k--)
      if (req[src_idx_t'(k)]) winner = src_idx_t'(k);
  end
`else
  always_comb begin : rr
    src_idx_t sel;
    logic     found;
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int d = 1; d <= N_SRC; d++) begin
      sel = src_idx_t'((int'(last) + d) % N_SRC);
      if (!found && req[sel]) begin
        winner = sel;
        found  = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular arbiter: grants one source from SOP to EOP and forwards its
// beats to the converter input with zero latency.
module ast_packet_arbiter
  import ast_packet_arbiter_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 srst_i,
  ast_packet_arbiter_if.slave  src,
  ast_packet_arbiter_if.master snk,
  output src_idx_t             grant_idx_o,
  output logic                 busy_o,
  output logic                 drop_o
);
  arb_state_t state;
  src_idx_t   last, winner;
  src_mask_t  req, stray;
  logic       any_req, eop_hs;

  assign req    = src.valid & src.startofpacket;
  assign stray  = src.valid & ~src.startofpacket;
  assign eop_hs = src.valid[grant_idx_o] & snk.ready[0] & src.endofpacket[grant_idx_o];
  assign busy_o = (state == BUSY);

  ast_rr_pick u_pick (
    .req     (req),
    .last    (last),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= IDLE;
      grant_idx_o <= '0;
      last        <= src_idx_t'(N_SRC-1);
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state       <= BUSY;
          grant_idx_o <= winner;
          last        <= winner;
        end
        BUSY: if (eop_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // IDLE holds SOP beats back for arbitration and swallows stray mid-packet beats.
  always_comb begin
    snk.data[0]          = src.data[grant_idx_o];
    snk.empty[0]         = src.empty[grant_idx_o];
    snk.channel[0]       = src.channel[grant_idx_o];
    snk.startofpacket[0] = src.startofpacket[grant_idx_o];
    snk.endofpacket[0]   = src.endofpacket[grant_idx_o];
    snk.valid[0]         = (state == BUSY) & src.valid[grant_idx_o];
    src.ready            = '0;
    drop_o               = 1'b0;
    if (state == BUSY) begin
      src.ready[grant_idx_o] = snk.ready[0];
    end else begin
      src.ready = stray;
      drop_o    = |stray;
    end
  end
endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Randomized + directed bench for ast_packet_arbiter with a queue-based reference model.
module tb_ast_packet_arbiter;
  import ast_packet_arbiter_pkg::*;

  typedef struct {
    logic [DATA_W-1:0]    data;
    logic [EMPTY_W-1:0]   empty;
    logic [CHANNEL_W-1:0] channel;
    logic                 sop;
    logic                 eop;
  } beat_t;

  logic     clk_i  = 1'b0;
  logic     srst_i = 1'b1;
  src_idx_t grant_idx_o;
  logic     busy_o, drop_o;

  ast_packet_arbiter_if #(.NUM_LANES(N_SRC)) src ();
  ast_packet_arbiter_if #(.NUM_LANES(1))     snk ();

  ast_packet_arbiter dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .src         (src),
    .snk         (snk),
    .grant_idx_o (grant_idx_o),
    .busy_o      (busy_o),
    .drop_o      (drop_o)
  );

  always #5 clk_i = ~clk_i;

  int    n_cmp = 0, n_err = 0;
  beat_t txq  [N_SRC][$];
  beat_t expq [N_SRC][$];
  logic [DATA_W-1:0] seen[$];
  int    dut_grants[$];
  int    dut_drops;
  bit    m_busy, prev_busy;
  int    m_g, m_last;
  int    vmode, rmode;
  bit    rpat[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule straight from the priority description.
  function automatic int pick(input logic [N_SRC-1:0] req, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < N_SRC; k++) if (req[k]) return k + 0 * last;
`else
    for (int d = 1; d <= N_SRC; d++) if (req[(last + d) % N_SRC]) return (last + d) % N_SRC;
`endif
    return -1;
  endfunction

  function automatic bit pending();
    for (int k = 0; k < N_SRC; k++) if (txq[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_pkt(input int k, input int n, input logic [DATA_W-1:0] step);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data    = (step != 0) ? DATA_W'(step * (i + 1)) : {$urandom, $urandom};
      b.empty   = EMPTY_W'($urandom);
      b.channel = CHANNEL_W'($urandom);
      b.sop     = (i == 0);
      b.eop     = (i == n - 1);
      txq[k].push_back(b);
      expq[k].push_back(b);
    end
  endtask

  task automatic push_stray(input int k, input logic [DATA_W-1:0] d);
    beat_t b;
    b.data = d; b.empty = '0; b.channel = '0; b.sop = 1'b0; b.eop = 1'b0;
    txq[k].push_back(b);
  endtask

  task automatic drive();
    for (int k = 0; k < N_SRC; k++) begin
      bit en;
      en = (vmode == 0) || ($urandom_range(3) != 0);
      if (txq[k].size() > 0 && en) begin
        src.valid[k]         = 1'b1;
        src.data[k]          = txq[k][0].data;
        src.empty[k]         = txq[k][0].empty;
        src.channel[k]       = txq[k][0].channel;
        src.startofpacket[k] = txq[k][0].sop;
        src.endofpacket[k]   = txq[k][0].eop;
      end else begin
        src.valid[k]         = 1'b0;
        src.data[k]          = {$urandom, $urandom};
        src.empty[k]         = '0;
        src.channel[k]       = '0;
        src.startofpacket[k] = 1'($urandom);
        src.endofpacket[k]   = 1'($urandom);
      end
    end
    case (rmode)
      0:       snk.ready[0] = 1'b1;
      1:       snk.ready[0] = 1'($urandom_range(1));
      default: snk.ready[0] = (rpat.size() > 0) ? rpat.pop_front() : 1'b1;
    endcase
  endtask

  task automatic tick();
    logic [N_SRC-1:0] req, stray, erdy;
    logic evld;
    int   p;
    beat_t b;
    @(negedge clk_i);
    req   = src.valid & src.startofpacket;
    stray = src.valid & ~src.startofpacket;
    erdy  = '0;
    if (m_busy) begin
      evld = src.valid[m_g];
      erdy[m_g] = snk.ready[0];
    end else begin
      evld = 1'b0;
      erdy = stray;
    end
    chk("valid_o", snk.valid[0], evld);
    chk("ready_o", src.ready, erdy);
    chk("drop_o", drop_o, !m_busy && stray != 0);
    chk("busy_o", busy_o, m_busy);
    chk("grant_idx_o", grant_idx_o, m_g);
    if (drop_o) dut_drops++;
    if (busy_o && !prev_busy) dut_grants.push_back(int'(grant_idx_o));
    prev_busy = busy_o;
    if (snk.valid[0] && snk.ready[0]) begin
      seen.push_back(snk.data[0]);
      if (!m_busy || expq[m_g].size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        b = expq[m_g].pop_front();
        chk("data", snk.data[0], b.data);
        chk("empty", snk.empty[0], b.empty);
        chk("channel", snk.channel[0], b.channel);
        chk("sop", snk.startofpacket[0], b.sop);
        chk("eop", snk.endofpacket[0], b.eop);
      end
    end
    for (int k = 0; k < N_SRC; k++)
      if (src.valid[k] && src.ready[k]) void'(txq[k].pop_front());
    if (srst_i) begin
      m_busy = 1'b0; m_g = 0; m_last = N_SRC - 1;
    end else if (m_busy) begin
      if (src.valid[m_g] && snk.ready[0] && src.endofpacket[m_g]) m_busy = 1'b0;
    end else begin
      p = pick(req, m_last);
      if (p >= 0) begin m_busy = 1'b1; m_g = p; m_last = p; end
    end
    @(posedge clk_i); #1;
    drive();
  endtask

  task automatic run_idle(input int limit);
    int n;
    n = 0;
    while ((m_busy || pending()) && n < limit) begin tick(); n++; end
    chk("drain_timeout", n >= limit, 0);
  endtask

  task automatic pulse_reset();
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
  endtask

  initial begin
    int n;
    int exp3[5];
    int exp7[3];
    vmode = 0; rmode = 0; m_busy = 0; m_g = 0; m_last = N_SRC - 1;
    prev_busy = 0; dut_drops = 0;
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    pulse_reset();
    tick();

    // src2 three-beat packet
    seen.delete(); dut_grants.delete();
    push_pkt(2, 3, 'h11);
    drive();
    run_idle(50);
    chk("src2_len", seen.size(), 3);
    for (int i = 0; i < seen.size() && i < 3; i++) chk("src2_data", seen[i], 64'('h11 * (i + 1)));
    chk("src2_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 2);
    tick();
    chk("src2_busy_fall", busy_o, 0);

    // every source streams single-beat packets
    pulse_reset();
    dut_grants.delete();
    for (int k = 0; k < N_SRC; k++) for (int j = 0; j < 5; j++) push_pkt(k, 1, '0);
    drive();
    run_idle(400);
`ifdef ARB_FIXED_PRIO_EN
    exp3 = '{0, 0, 0, 0, 0};
`else
    exp3 = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) chk("grant_order", (dut_grants.size() > i) ? dut_grants[i] : -1, exp3[i]);

    // src1 under alternating backpressure
    rmode = 2;
    for (int i = 0; i < 8; i++) begin rpat.push_back(1'b1); rpat.push_back(1'b0); end
    seen.delete();
    push_pkt(1, 4, 'h1000);
    drive();
    run_idle(60);
    chk("bp_len", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++) chk("bp_data", seen[i], 64'('h1000 * (i + 1)));
    rmode = 0; rpat.delete();

    // stray beat while idle
    seen.delete(); dut_drops = 0;
    push_stray(3, 'hDEAD);
    drive();
    run_idle(20);
    chk("stray_drops", dut_drops, 1);
    chk("stray_fwd", seen.size(), 0);

    // reset in the middle of a five-beat packet
    seen.delete();
    push_pkt(1, 5, 'h100);
    drive();
    n = 0;
    while (seen.size() < 1 && n < 50) begin tick(); n++; end
    chk("mid_rst_timeout", n >= 50, 0);
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    expq[1].delete();
    dut_drops = 0; dut_grants.delete();
    push_pkt(0, 2, 'h500);
    push_pkt(2, 2, 'h600);
    drive();
    run_idle(200);
    chk("reset_drops", dut_drops, 3);
    chk("post_reset_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);

    // new requests land on the EOP handshake of src1
    dut_grants.delete();
    push_pkt(1, 3, 'h700);
    drive();
    n = 0;
    while (expq[1].size() > 1 && n < 50) begin tick(); n++; end
    chk("eop_sync_timeout", n >= 50, 0);
    push_pkt(0, 2, 'h800);
    push_pkt(2, 2, 'h900);
    drive();
    run_idle(200);
`ifdef ARB_FIXED_PRIO_EN
    exp7 = '{1, 0, 2};
`else
    exp7 = '{1, 2, 0};
`endif
    for (int i = 0; i < 3; i++) chk("eop_race_grant", (dut_grants.size() > i) ? dut_grants[i] : -1, exp7[i]);

    // random traffic with gaps, backpressure and stray beats
    vmode = 1; rmode = 1;
    for (int c = 0; c < 1500; c++) begin
      int k;
      k = $urandom_range(N_SRC - 1);
      if (txq[k].size() < 6 && $urandom_range(3) == 0) begin
        if ($urandom_range(7) == 0) push_stray(k, {$urandom, $urandom});
        else push_pkt(k, $urandom_range(6, 1), '0);
      end
      tick();
    end
    run_idle(3000);
    for (int k = 0; k < N_SRC; k++) chk("leftover", expq[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
